// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider sharing one datapath.
// Define MDU_FAST_MUL_EN to complete multiplies in one cycle with a combinational multiplier.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] f
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] f_q, f_d;

  logic             a_signed, b_signed, a_neg, b_neg, is_div, b_zero, ovf;
  logic [WIDTH-1:0] mag_a, mag_b, special_f;

  always_comb begin
    a_signed  = (mdu_op == 3'b001) || (mdu_op == 3'b010) ||
                (mdu_op == 3'b100) || (mdu_op == 3'b110);
    b_signed  = (mdu_op == 3'b001) || (mdu_op == 3'b100) || (mdu_op == 3'b110);
    a_neg     = a_signed & a[WIDTH-1];
    b_neg     = b_signed & b[WIDTH-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
    is_div    = mdu_op[2];
    b_zero    = (b == '0);
    ovf       = is_div && !mdu_op[0] && (a == MIN_NEG) && (b == '1);
    if (b_zero) special_f = mdu_op[1] ? a : '1;
    else        special_f = mdu_op[1] ? '0 : a;
  end

  // hi:lo is the product for multiplies, remainder:quotient-in-progress for divides
  logic [WIDTH:0]       mul_sum, div_shl, div_diff;
  logic [WIDTH-1:0]     step_hi, step_lo, div_res, fin_f;
  logic [2*WIDTH-1:0]   prod;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shl  = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_shl - {1'b0, opnd_q};
    if (op_q[2]) begin
      step_hi = div_diff[WIDTH] ? div_shl[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    div_res = op_q[1] ? hi_q : lo_q;
    if (op_q[2])              fin_f = neg_q ? -div_res : div_res;
    else if (op_q == 3'b000)  fin_f = prod[WIDTH-1:0];
    else                      fin_f = prod[2*WIDTH-1:WIDTH];
  end

  logic             fast_take;
  logic [WIDTH-1:0] fast_f;
`ifdef MDU_FAST_MUL_EN
  // Sign-extended operands multiplied modulo 2^(2*WIDTH) give the exact low 2*WIDTH product bits
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
  always_comb begin
    fast_a    = {{WIDTH{a_neg}}, a};
    fast_b    = {{WIDTH{b_neg}}, b};
    fast_prod = fast_a * fast_b;
    fast_take = !is_div;
    fast_f    = (mdu_op == 3'b000) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
  end
`else
  assign fast_take = 1'b0;
  assign fast_f    = '0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    f_d     = f_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = mdu_op;
          neg_d = (is_div && mdu_op[1]) ? a_neg : (a_neg ^ b_neg);
          if (is_div && (b_zero || ovf)) begin
            f_d     = special_f;
            state_d = DONE;
          end else if (fast_take) begin
            f_d     = fast_f;
            state_d = DONE;
          end else begin
            hi_d    = '0;
            lo_d    = is_div ? mag_a : mag_b;
            opnd_d  = is_div ? mag_b : mag_a;
            cnt_d   = CW'(WIDTH - 1);
            last_d  = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (last_q) begin
          f_d     = fin_f;
          last_d  = 1'b0;
          state_d = DONE;
        end else begin
          hi_d = step_hi;
          lo_d = step_lo;
          if (cnt_q == '0) last_d = 1'b1;
          else             cnt_d  = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flush kills everything, including a request offered in the same cycle
    if (flush) begin
      state_d = IDLE;
      f_d     = f_q;
      cnt_d   = '0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      f_q     <= f_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign f          = f_q;

endmodule
